sad_search_ctrl: RTL and testbench

- Sequencer for the 4-pixel-wide SAD datapath in a block-matching search.
- Steps through NUM_CAND candidate blocks of NUM_STEPS 4-pixel groups each, and drives the datapath's rst/en_in/en_acum/en_out.
- Reads each candidate's out_sad, tracks the minimum SAD and its candidate index, and reports through a start/done handshake.
- Drives the pixel-fetch indices (cand_idx, step_idx) used by the memory front-end.

---
 rtl/sad_search_ctrl.sv | 141 ++++++++++++++
 tb/tb_sad_search_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_search_ctrl.sv
// sad_search_ctrl: sequences a 4-pixel SAD datapath over NUM_CAND candidates and keeps the minimum SAD.
// Optional early-exit threshold compare is built when SAD_SEARCH_CTRL_THRESH_EN is defined.
module sad_search_ctrl #(
  parameter int WIDTH     = 8,
  parameter int NUM_STEPS = 4,
  parameter int NUM_CAND  = 16,
  localparam int CAND_W   = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1,
  localparam int STEP_W   = $clog2(NUM_STEPS),
  localparam int SAD_W    = WIDTH + 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pix_valid,
  input  logic [SAD_W-1:0]  sad_in,
`ifdef SAD_SEARCH_CTRL_THRESH_EN
  input  logic [SAD_W-1:0]  thresh,
  output logic              early_hit,
`endif
  output logic              sad_rst,
  output logic              en_in,
  output logic              en_acum,
  output logic              en_out,
  output logic [CAND_W-1:0] cand_idx,
  output logic [STEP_W-1:0] step_idx,
  output logic              busy,
  output logic              done,
  output logic [SAD_W-1:0]  best_sad,
  output logic [CAND_W-1:0] best_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LOAD, S_FLUSH, S_CMP, S_FIN
  } state_t;

  state_t             state_q;
  logic               sad_rst_q, en_acum_q, en_out_q, busy_q, done_q;
  logic [CAND_W-1:0]  cand_q, best_idx_q;
  logic [STEP_W-1:0]  step_q;
  logic [SAD_W-1:0]   best_sad_q;
  logic               last_step, last_cand, better, thresh_hit;

`ifdef SAD_SEARCH_CTRL_THRESH_EN
  logic [SAD_W-1:0]   thresh_q;
  logic               early_hit_q;
  assign thresh_hit = (sad_in <= thresh_q);
  assign early_hit  = early_hit_q;
`else
  assign thresh_hit = 1'b0;
`endif

  assign last_step = (step_q == STEP_W'(NUM_STEPS - 1));
  assign last_cand = (cand_q == CAND_W'(NUM_CAND - 1));
  assign better    = (sad_in < best_sad_q);

  // en_in is the only combinational enable so a fetch can load in the cycle it arrives.
  assign en_in    = (state_q == S_LOAD) && pix_valid;
  assign sad_rst  = sad_rst_q;
  assign en_acum  = en_acum_q;
  assign en_out   = en_out_q;
  assign cand_idx = cand_q;
  assign step_idx = step_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign best_sad = best_sad_q;
  assign best_idx = best_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sad_rst_q   <= 1'b0;
      en_acum_q   <= 1'b0;
      en_out_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cand_q      <= '0;
      step_q      <= '0;
      best_sad_q  <= '0;
      best_idx_q  <= '0;
`ifdef SAD_SEARCH_CTRL_THRESH_EN
      thresh_q    <= '0;
      early_hit_q <= 1'b0;
`endif
    end else begin
      sad_rst_q <= 1'b0;
      done_q    <= 1'b0;
      en_acum_q <= en_in && !last_step;
      en_out_q  <= en_in && last_step;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_CLR;
            busy_q     <= 1'b1;
            sad_rst_q  <= 1'b1;
            cand_q     <= '0;
            step_q     <= '0;
            best_sad_q <= '1;
            best_idx_q <= '0;
`ifdef SAD_SEARCH_CTRL_THRESH_EN
            thresh_q    <= thresh;
            early_hit_q <= 1'b0;
`endif
          end
        end
        S_CLR: state_q <= S_LOAD;
        S_LOAD: begin
          if (pix_valid) begin
            if (last_step) begin
              step_q  <= '0;
              state_q <= S_FLUSH;
            end else begin
              step_q <= step_q + STEP_W'(1);
            end
          end
        end
        S_FLUSH: state_q <= S_CMP;
        S_CMP: begin
          if (better) begin
            best_sad_q <= sad_in;
            best_idx_q <= cand_q;
          end
          if (thresh_hit || last_cand) begin
`ifdef SAD_SEARCH_CTRL_THRESH_EN
            if (thresh_hit) early_hit_q <= 1'b1;
`endif
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cand_q    <= cand_q + CAND_W'(1);
            sad_rst_q <= 1'b1;
            state_q   <= S_CLR;
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_search_ctrl.sv
// tb_sad_search_ctrl: random and directed stimulus against a timeline model of the search sequencer.
module tb_sad_search_ctrl;
  localparam int NS = 4, NC = 4, W = 8, SW = W + 5, CW = 2, STW = 2;
  localparam int MAXT = 1200, MAXS = 64;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, pix_valid = 1'b0;
  logic [SW-1:0] sad_in = '0;
  logic sad_rst, en_in, en_acum, en_out, busy, done;
  logic [CW-1:0] cand_idx, best_idx;
  logic [STW-1:0] step_idx;
  logic [SW-1:0] best_sad;
`ifdef SAD_SEARCH_CTRL_THRESH_EN
  logic [SW-1:0] thresh = '0;
  logic early_hit;
`endif

  always #5 clk = ~clk;

  sad_search_ctrl #(.WIDTH(W), .NUM_STEPS(NS), .NUM_CAND(NC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid), .sad_in(sad_in),
`ifdef SAD_SEARCH_CTRL_THRESH_EN
    .thresh(thresh), .early_hit(early_hit),
`endif
    .sad_rst(sad_rst), .en_in(en_in), .en_acum(en_acum), .en_out(en_out),
    .cand_idx(cand_idx), .step_idx(step_idx), .busy(busy), .done(done),
    .best_sad(best_sad), .best_idx(best_idx)
  );

  int total = 0, bad = 0;

  // stimulus per cycle and per-search SAD tables
  bit st[MAXT], pv[MAXT];
  logic [SW-1:0] sd[MAXT];
  logic [SW-1:0] tab[MAXS][NC];

  // expected outputs per cycle
  bit e_rst[MAXT], e_in[MAXT], e_acum[MAXT], e_out[MAXT], e_busy[MAXT], e_done[MAXT], e_hit[MAXT];
  bit e_ckc[MAXT], e_cks[MAXT];
  int e_cand[MAXT], e_step[MAXT], e_bidx[MAXT];
  logic [SW-1:0] e_best[MAXT];

  task automatic chk(input string nm, input int t, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, t, act, exp);
    end
  endtask

  function automatic void put(input int t, input bit bz, input bit ckc, input int c,
                              input bit cks, input int s, input logic [SW-1:0] b,
                              input int bi, input bit h);
    e_busy[t] = bz; e_ckc[t] = ckc; e_cand[t] = c; e_cks[t] = cks; e_step[t] = s;
    e_best[t] = b; e_bidx[t] = bi; e_hit[t] = h;
  endfunction

  // Walk the stimulus in time: a search is a run of candidates, each a clear,
  // NUM_STEPS accepted fetches (stalls in between), a flush and a compare.
  function automatic void build(input int n);
    int t, k, bidx;
    logic [SW-1:0] best, v;
    bit hit, stop;
    for (int i = 0; i < MAXT; i++) begin
      e_rst[i] = 0; e_in[i] = 0; e_acum[i] = 0; e_out[i] = 0; e_done[i] = 0;
      put(i, 0, 0, 0, 0, 0, '0, 0, 0);
    end
    best = '0; bidx = 0; hit = 0; k = 0; t = 0;
    while (t < n) begin
      put(t, 0, 0, 0, 0, 0, best, bidx, hit);
      if (!st[t]) begin
        t++;
      end else begin
        t++;
        best = '1; bidx = 0; hit = 0; stop = 0;
        for (int c = 0; c < NC && !stop; c++) begin
          put(t, 1, 1, c, 1, 0, best, bidx, hit); e_rst[t] = 1; t++;
          for (int s = 0; s < NS; s++) begin
            while (t < MAXT - 100 && !pv[t]) begin
              put(t, 1, 1, c, 1, s, best, bidx, hit); t++;
            end
            put(t, 1, 1, c, 1, s, best, bidx, hit); e_in[t] = 1;
            if (s == NS - 1) e_out[t+1] = 1; else e_acum[t+1] = 1;
            t++;
          end
          put(t, 1, 1, c, 0, 0, best, bidx, hit); t++;
          put(t, 1, 1, c, 0, 0, best, bidx, hit);
          v = tab[k % MAXS][c]; sd[t] = v; t++;
          if (v < best) begin best = v; bidx = c; end
`ifdef SAD_SEARCH_CTRL_THRESH_EN
          if (v <= thresh) begin hit = 1; stop = 1; end
`endif
        end
        put(t, 0, 0, 0, 0, 0, best, bidx, hit); e_done[t] = 1; t++; k++;
      end
    end
  endfunction

  task automatic set_stim(input int sprob, input int pvprob, input int maxsad);
    for (int t = 0; t < MAXT; t++) begin
      st[t] = ($urandom_range(0, 99) < sprob);
      pv[t] = ($urandom_range(0, 99) < pvprob);
      sd[t] = SW'($urandom);
    end
    for (int k = 0; k < MAXS; k++)
      for (int c = 0; c < NC; c++) tab[k][c] = SW'($urandom_range(0, maxsad));
  endtask

  task automatic directed(input int a, input int s0, input int s1, input int s2, input int s3);
    set_stim(0, 100, 100);
    st[a] = 1;
    tab[0][0] = SW'(s0); tab[0][1] = SW'(s1); tab[0][2] = SW'(s2); tab[0][3] = SW'(s3);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".sad_rst"}, 0, longint'(sad_rst), 0);
    chk({nm, ".en_in"}, 0, longint'(en_in), 0);
    chk({nm, ".en_acum"}, 0, longint'(en_acum), 0);
    chk({nm, ".en_out"}, 0, longint'(en_out), 0);
    chk({nm, ".cand_idx"}, 0, longint'(cand_idx), 0);
    chk({nm, ".step_idx"}, 0, longint'(step_idx), 0);
    chk({nm, ".busy"}, 0, longint'(busy), 0);
    chk({nm, ".done"}, 0, longint'(done), 0);
    chk({nm, ".best_sad"}, 0, longint'(best_sad), 0);
    chk({nm, ".best_idx"}, 0, longint'(best_idx), 0);
`ifdef SAD_SEARCH_CTRL_THRESH_EN
    chk({nm, ".early_hit"}, 0, longint'(early_hit), 0);
`endif
  endtask

  // Drive n cycles of stimulus and compare every output against the timeline.
  task automatic run(input int n, output int done_t, output int n_done,
                     output int c_rst, output int c_in, output int c_acum, output int c_out);
    build(n);
    done_t = -1; n_done = 0; c_rst = 0; c_in = 0; c_acum = 0; c_out = 0;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      start = st[t]; pix_valid = pv[t]; sad_in = sd[t];
      #1;
      chk("sad_rst", t, longint'(sad_rst), longint'(e_rst[t]));
      chk("en_in", t, longint'(en_in), longint'(e_in[t]));
      chk("en_acum", t, longint'(en_acum), longint'(e_acum[t]));
      chk("en_out", t, longint'(en_out), longint'(e_out[t]));
      chk("busy", t, longint'(busy), longint'(e_busy[t]));
      chk("done", t, longint'(done), longint'(e_done[t]));
      chk("best_sad", t, longint'(best_sad), longint'(e_best[t]));
      chk("best_idx", t, longint'(best_idx), longint'(e_bidx[t]));
      if (e_ckc[t]) chk("cand_idx", t, longint'(cand_idx), longint'(e_cand[t]));
      if (e_cks[t]) chk("step_idx", t, longint'(step_idx), longint'(e_step[t]));
`ifdef SAD_SEARCH_CTRL_THRESH_EN
      chk("early_hit", t, longint'(early_hit), longint'(e_hit[t]));
`endif
      if (done) begin n_done++; if (done_t < 0) done_t = t; end
      c_rst += int'(sad_rst); c_in += int'(en_in);
      c_acum += int'(en_acum); c_out += int'(en_out);
    end
  endtask

  task automatic chk_plan(input string nm, input int dt, input int nd,
                          input int cr, input int ci, input int ca, input int co,
                          input int want_lat, input int want_sad, input int want_idx);
    chk({nm, ".latency"}, 0, longint'(dt - 1), longint'(want_lat));
    chk({nm, ".done_count"}, 0, longint'(nd), 1);
    chk({nm, ".n_sad_rst"}, 0, longint'(cr), 4);
    chk({nm, ".n_en_in"}, 0, longint'(ci), 16);
    chk({nm, ".n_en_acum"}, 0, longint'(ca), 12);
    chk({nm, ".n_en_out"}, 0, longint'(co), 4);
    chk({nm, ".best_sad"}, 0, longint'(best_sad), longint'(want_sad));
    chk({nm, ".best_idx"}, 0, longint'(best_idx), longint'(want_idx));
  endtask

  initial begin
    int dt, nd, cr, ci, ca, co;
    #2;
    chk_zero("reset");
    do_reset();

    directed(1, 40, 25, 60, 30);
    run(40, dt, nd, cr, ci, ca, co);
    chk_plan("plan", dt, nd, cr, ci, ca, co, 29, 25, 1);

    do_reset();
    directed(1, 40, 25, 60, 30);
    pv[11] = 0; pv[12] = 0; pv[13] = 0;
    run(40, dt, nd, cr, ci, ca, co);
    chk_plan("stall", dt, nd, cr, ci, ca, co, 32, 25, 1);

    do_reset();
    directed(1, 30, 30, 30, 30);
    run(40, dt, nd, cr, ci, ca, co);
    chk_plan("tie", dt, nd, cr, ci, ca, co, 29, 30, 0);

    do_reset();
    set_stim(100, 100, 200);
    run(62, dt, nd, cr, ci, ca, co);
    chk("held_start.done_count", 0, longint'(nd), 2);

    for (int r = 0; r < 6; r++) begin
      do_reset();
      set_stim(10, 70, (r < 3) ? 15 : 8191);
      run(200, dt, nd, cr, ci, ca, co);
    end

    do_reset();
    directed(1, 40, 25, 60, 30);
    run(19, dt, nd, cr, ci, ca, co);
    chk("midreset.in_cand2", 0, longint'(cand_idx), 2);
    #1 rst_n = 1'b0;
    #1 chk_zero("midreset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    directed(1, 40, 25, 60, 30);
    run(40, dt, nd, cr, ci, ca, co);
    chk_plan("after_reset", dt, nd, cr, ci, ca, co, 29, 25, 1);

`ifdef SAD_SEARCH_CTRL_THRESH_EN
    do_reset();
    thresh = SW'(26);
    directed(1, 40, 25, 60, 30);
    run(30, dt, nd, cr, ci, ca, co);
    chk("thresh.latency", 0, longint'(dt - 1), 15);
    chk("thresh.early_hit", 0, longint'(early_hit), 1);
    chk("thresh.best_sad", 0, longint'(best_sad), 25);
    chk("thresh.best_idx", 0, longint'(best_idx), 1);
    do_reset();
    set_stim(10, 70, 60);
    thresh = SW'(12);
    run(200, dt, nd, cr, ci, ca, co);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
